rptr_empty: RTL and testbench



---
 rtl/rptr_empty.sv | 73 +++++++
 tb/tb_rptr_empty.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty.sv
// Read-side pointer and status block of an async FIFO; all state lives in rclk.
// Ports: rclk/rrst_n clock and async active-low reset; rinc pop request;
//   rq2_wptr synchronised Gray write pointer; clr_underflow clears the sticky error;
//   raddr binary memory address; rptr Gray read pointer to the write domain;
//   rempty/ralmost_empty/rlevel registered status; runderflow sticky underflow flag.
module rptr_empty #(
  parameter int FIFO_ADDRSIZE   = 2,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic                     rinc,
  input  logic [FIFO_ADDRSIZE:0]   rq2_wptr,
  input  logic                     clr_underflow,
  output logic [FIFO_ADDRSIZE-1:0] raddr,
  output logic [FIFO_ADDRSIZE:0]   rptr,
  output logic                     rempty,
  output logic                     ralmost_empty,
  output logic [FIFO_ADDRSIZE:0]   rlevel,
  output logic                     runderflow
);

  localparam int PW = FIFO_ADDRSIZE + 1;
  localparam logic [FIFO_ADDRSIZE:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  logic [FIFO_ADDRSIZE:0] rbin;
  logic [FIFO_ADDRSIZE:0] rbinnext;
  logic [FIFO_ADDRSIZE:0] rgraynext;
  logic [FIFO_ADDRSIZE:0] wbin;
  logic [FIFO_ADDRSIZE:0] rlevelnext;
  logic                   pop;

  // A request against an empty FIFO is dropped here and only flags underflow.
  assign pop       = rinc & ~rempty;
  assign rbinnext  = rbin + PW'(pop);
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < PW; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  // The extra pointer MSB makes this subtraction distinguish full (depth) from empty (0).
  assign rlevelnext = wbin - rbinnext;

  // Memory reads the current head entry directly from the registered pointer.
  assign raddr = rbin[FIFO_ADDRSIZE-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      // Compared against the synchronised (stale) write pointer, so empty is
      // only ever pessimistic: it can linger but never clears early.
      rempty        <= (rgraynext == rq2_wptr);
      rlevel        <= rlevelnext;
      ralmost_empty <= (rlevelnext <= AE_TH);
      // Set has priority over a same-cycle clear.
      runderflow    <= (rinc & rempty) | (runderflow & ~clr_underflow);
    end
  end

endmodule

// File: tb/tb_rptr_empty.sv
module tb_rptr_empty;

  logic       rclk;
  logic       rrst_n;
  logic       rinc;
  logic [2:0] rq2_wptr;
  logic       clr_underflow;
  logic [1:0] raddr;
  logic [2:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic [2:0] rlevel;
  logic       runderflow;

  int total = 0;
  int bad   = 0;

  rptr_empty #(.FIFO_ADDRSIZE(2), .ALMOST_EMPTY_TH(1)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .clr_underflow (clr_underflow),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it before checking.
  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  function automatic logic [2:0] gray(input logic [2:0] b);
    return (b >> 1) ^ b;
  endfunction

  initial begin
    logic [2:0] wb;
    logic [2:0] rb;

    rrst_n        = 1'b0;
    rinc          = 1'b0;
    rq2_wptr      = 3'b000;
    clr_underflow = 1'b0;
    #13;
    chk("rst_rempty", 8'(rempty), 8'h1);
    chk("rst_ralmost", 8'(ralmost_empty), 8'h1);
    chk("rst_rptr", 8'(rptr), 8'h0);
    chk("rst_raddr", 8'(raddr), 8'h0);
    chk("rst_rlevel", 8'(rlevel), 8'h0);
    chk("rst_runder", 8'(runderflow), 8'h0);
    rrst_n = 1'b1;
    step();
    chk("idle_rempty", 8'(rempty), 8'h1);

    // Drain: three entries written.
    rq2_wptr = 3'b010;
    step();
    chk("d0_rempty", 8'(rempty), 8'h0);
    chk("d0_rlevel", 8'(rlevel), 8'h3);
    chk("d0_ralmost", 8'(ralmost_empty), 8'h0);
    chk("d0_raddr", 8'(raddr), 8'h0);
    rinc = 1'b1;
    step();
    chk("d1_raddr", 8'(raddr), 8'h1);
    chk("d1_rptr", 8'(rptr), 8'h1);
    chk("d1_rlevel", 8'(rlevel), 8'h2);
    chk("d1_ralmost", 8'(ralmost_empty), 8'h0);
    chk("d1_rempty", 8'(rempty), 8'h0);
    step();
    chk("d2_raddr", 8'(raddr), 8'h2);
    chk("d2_rptr", 8'(rptr), 8'h3);
    chk("d2_rlevel", 8'(rlevel), 8'h1);
    chk("d2_ralmost", 8'(ralmost_empty), 8'h1);
    chk("d2_rempty", 8'(rempty), 8'h0);
    step();
    chk("d3_raddr", 8'(raddr), 8'h3);
    chk("d3_rptr", 8'(rptr), 8'h2);
    chk("d3_rlevel", 8'(rlevel), 8'h0);
    chk("d3_rempty", 8'(rempty), 8'h1);
    chk("d3_runder", 8'(runderflow), 8'h0);

    // Underflow: rinc still high while empty.
    step();
    chk("u0_rptr", 8'(rptr), 8'h2);
    chk("u0_raddr", 8'(raddr), 8'h3);
    chk("u0_runder", 8'(runderflow), 8'h1);
    rinc = 1'b0;
    step();
    chk("u1_hold", 8'(runderflow), 8'h1);
    clr_underflow = 1'b1;
    step();
    chk("u2_clear", 8'(runderflow), 8'h0);
    rinc = 1'b1;
    step();
    chk("u3_setwins", 8'(runderflow), 8'h1);
    chk("u3_rptr", 8'(rptr), 8'h2);
    rinc          = 1'b0;
    clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
    chk("u4_clear", 8'(runderflow), 8'h0);

    // Wrap: writer stays two entries ahead while nine entries stream out.
    wb       = 3'd5;
    rq2_wptr = gray(wb);
    step();
    chk("w_pre_rlevel", 8'(rlevel), 8'h2);
    rb   = 3'd3;
    rinc = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wb       = wb + 3'd1;
      rq2_wptr = gray(wb);
      rb       = rb + 3'd1;
      step();
      chk("w_rptr", 8'(rptr), 8'(gray(rb)));
      chk("w_raddr", 8'(raddr), 8'(rb[1:0]));
      chk("w_rempty", 8'(rempty), 8'h0);
      chk("w_rlevel", 8'(rlevel), 8'h2);
    end
    rinc = 1'b0;
    chk("w_end_rptr", 8'(rptr), 8'h6);

    // Mid-cycle reset with the write side reset alongside.
    #2;
    rrst_n   = 1'b0;
    rq2_wptr = 3'b000;
    #1;
    chk("r2_rempty", 8'(rempty), 8'h1);
    chk("r2_ralmost", 8'(ralmost_empty), 8'h1);
    chk("r2_rptr", 8'(rptr), 8'h0);
    chk("r2_raddr", 8'(raddr), 8'h0);
    chk("r2_rlevel", 8'(rlevel), 8'h0);
    #3;
    rrst_n = 1'b1;
    step();

    // Full occupancy.
    rq2_wptr = 3'b110;
    step();
    chk("f_rlevel", 8'(rlevel), 8'h4);
    chk("f_rempty", 8'(rempty), 8'h0);
    chk("f_ralmost", 8'(ralmost_empty), 8'h0);

    // Drain to the last entry, then pop it while a write lands later.
    rinc = 1'b1;
    step();
    step();
    step();
    chk("s_pre_rlevel", 8'(rlevel), 8'h1);
    step();
    chk("s_pop_rempty", 8'(rempty), 8'h1);
    chk("s_pop_rlevel", 8'(rlevel), 8'h0);
    chk("s_pop_rptr", 8'(rptr), 8'h6);
    rinc     = 1'b0;
    rq2_wptr = 3'b111;
    step();
    chk("s_new_rempty", 8'(rempty), 8'h0);
    chk("s_new_rlevel", 8'(rlevel), 8'h1);
    chk("s_new_ralmost", 8'(ralmost_empty), 8'h1);
    chk("s_new_raddr", 8'(raddr), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
